multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide sharing one 2*WIDTH work register.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Long,
    output logic [3:0]       ALUFlags,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_LIMIT = WIDTH[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_SMUL = 4'b0101;
    localparam logic [3:0] OP_UMUL = 4'b0110;
    localparam logic [3:0] OP_UDIV = 4'b0111;
    localparam logic [3:0] OP_EOR  = 4'b1000;
    localparam logic [3:0] OP_MOV  = 4'b1001;
    localparam logic [3:0] OP_LSL  = 4'b1010;
    localparam logic [3:0] OP_LSR  = 4'b1011;
    localparam logic [3:0] OP_ASR  = 4'b1100;
    localparam logic [3:0] OP_SDIV = 4'b1101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   long_q, long_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;

    logic               is_iter;
    logic [WIDTH-1:0]   a_mag, b_mag, b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sc_result;
    logic [3:0]         sc_flags;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   fin_result, fin_long;
    logic [3:0]         fin_flags;

    assign is_iter = (ALUControl == OP_MUL) || (ALUControl == OP_SMUL) ||
                     (ALUControl == OP_UMUL) || (ALUControl == OP_UDIV) ||
                     (ALUControl == OP_SDIV);
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // Single-cycle datapath; SUB reuses the adder with inverted b and carry-in.
    always_comb begin
        sc_result = '0;
        sc_flags  = '0;
        b_eff     = ALUControl[0] ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ALUControl[0]};
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                sc_result   = sum[WIDTH-1:0];
                sc_flags[1] = sum[WIDTH];
                sc_flags[0] = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: sc_result = a & b;
            OP_ORR: sc_result = a | b;
            OP_EOR: sc_result = a ^ b;
            OP_MOV: sc_result = b;
            OP_LSL: sc_result = (b >= W_LIMIT) ? '0 : (a << b);
            OP_LSR: sc_result = (b >= W_LIMIT) ? '0 : (a >> b);
            OP_ASR: sc_result = (b >= W_LIMIT) ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            default: sc_result = '0;
        endcase
        sc_flags[3] = sc_result[WIDTH-1];
        sc_flags[2] = (sc_result == '0);
    end

    // One iteration step of each engine; work_q is {high/remainder, low/quotient}.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     work_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod       = (op_q == OP_SMUL && neg_q) ? -mul_next : mul_next;
        quot       = div_next[WIDTH-1:0];
        rem        = div_next[2*WIDTH-1:WIDTH];
        fin_result = '0;
        fin_long   = '0;
        fin_flags  = '0;
        case (op_q)
            OP_SMUL, OP_UMUL: begin
                fin_result   = prod[WIDTH-1:0];
                fin_long     = prod[2*WIDTH-1:WIDTH];
                fin_flags[3] = prod[2*WIDTH-1];
                fin_flags[2] = (prod == '0);
            end
            OP_UDIV, OP_SDIV: begin
                if (dz_q) begin
                    fin_result = '1;
                    fin_long   = a_q;
                end else if (op_q == OP_SDIV) begin
                    fin_result = neg_q ? -quot : quot;
                    fin_long   = rem_neg_q ? -rem : rem;
                end else begin
                    fin_result = quot;
                    fin_long   = rem;
                end
                fin_flags[3] = fin_result[WIDTH-1];
                fin_flags[2] = (fin_result == '0);
                fin_flags[0] = dz_q | ovf_q;
            end
            default: begin
                fin_result   = prod[WIDTH-1:0];
                fin_long     = prod[2*WIDTH-1:WIDTH];
                fin_flags[3] = prod[WIDTH-1];
                fin_flags[2] = (prod[WIDTH-1:0] == '0);
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        a_d       = a_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        long_d    = long_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_iter) begin
                    state_d   = RUN;
                    count_d   = CW'(WIDTH - 1);
                    op_d      = ALUControl;
                    a_d       = a;
                    neg_d     = a[WIDTH-1] ^ b[WIDTH-1];
                    rem_neg_d = a[WIDTH-1];
                    dz_d      = (b == '0);
                    ovf_d     = (ALUControl == OP_SDIV) && (a == MOST_NEG) && (b == '1);
                    case (ALUControl)
                        OP_SMUL: begin
                            opnd_d = a_mag;
                            work_d = {{WIDTH{1'b0}}, b_mag};
                        end
                        OP_SDIV: begin
                            opnd_d = b_mag;
                            work_d = {{WIDTH{1'b0}}, a_mag};
                        end
                        OP_UDIV: begin
                            opnd_d = b;
                            work_d = {{WIDTH{1'b0}}, a};
                        end
                        default: begin
                            opnd_d = a;
                            work_d = {{WIDTH{1'b0}}, b};
                        end
                    endcase
                end else if (start) begin
                    result_d = sc_result;
                    long_d   = '0;
                    flags_d  = sc_flags;
                    done_d   = 1'b1;
                end
            end
            RUN: begin
                work_d  = ((op_q == OP_UDIV) || (op_q == OP_SDIV)) ? div_next : mul_next;
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d  = IDLE;
                    count_d  = '0;
                    result_d = fin_result;
                    long_d   = fin_long;
                    flags_d  = fin_flags;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            a_q       <= '0;
            opnd_q    <= '0;
            work_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            long_q    <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            a_q       <= a_d;
            opnd_q    <= opnd_d;
            work_q    <= work_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            long_q    <= long_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
        end
    end

    assign Result   = result_q;
    assign Long     = long_q;
    assign ALUFlags = flags_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu (WIDTH=32) against an
// arithmetic reference model built on 64-bit integer operations.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic [3:0]  ALUControl;
    logic [31:0] Result, Long;
    logic [3:0]  ALUFlags;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ALUControl(ALUControl), .Result(Result), .Long(Long),
        .ALUFlags(ALUFlags), .busy(busy), .done(done)
    );

    function automatic bit is_iter_op(input logic [3:0] op);
        return (op == 4'd4) || (op == 4'd5) || (op == 4'd6) || (op == 4'd7) || (op == 4'd13);
    endfunction

    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] l, output logic [3:0] f);
        longint sx, sy, s;
        logic [63:0] p;
        logic n, z, c, v;
        r = '0; l = '0; c = 1'b0; v = 1'b0; p = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            4'd0: begin
                s = sx + sy; r = x + y;
                c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
                v = (s != longint'($signed(r)));
            end
            4'd1: begin
                s = sx - sy; r = x - y;
                c = (x >= y);
                v = (s != longint'($signed(r)));
            end
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd8:  r = x ^ y;
            4'd9:  r = y;
            4'd10: r = (y >= 32) ? 32'd0 : (x << y[4:0]);
            4'd11: r = (y >= 32) ? 32'd0 : (x >> y[4:0]);
            4'd12: r = (y >= 32) ? {32{x[31]}} : 32'($signed(x) >>> y[4:0]);
            4'd4, 4'd6: begin p = 64'(x) * 64'(y); r = p[31:0]; l = p[63:32]; end
            4'd5: begin p = 64'(sx * sy); r = p[31:0]; l = p[63:32]; end
            4'd7: begin
                if (y == 0) begin r = '1; l = x; v = 1'b1; end
                else begin r = x / y; l = x % y; end
            end
            4'd13: begin
                if (y == 0) begin r = '1; l = x; v = 1'b1; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = x; l = '0; v = 1'b1; end
                else begin r = 32'(sx / sy); l = 32'(sx % sy); end
            end
            default: begin r = '0; l = '0; end
        endcase
        n = r[31];
        z = (r == 0);
        if (op == 4'd5 || op == 4'd6) begin
            n = l[31];
            z = ({l, r} == 64'd0);
        end
        f = {n, z, c, v};
    endfunction

    // Issues one request, scrambles the inputs after acceptance, and waits for done.
    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int busy_cycles);
        @(negedge clk);
        a = x; b = y; ALUControl = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; ALUControl = 4'($urandom_range(0, 15));
        lat = 1; busy_cycles = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; a = '0; b = '0; ALUControl = '0;
        #12;
        n_tests++;
        if ({Result, Long, ALUFlags, busy, done} !== 70'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got R=%h L=%h F=%b busy=%b done=%b, want all 0",
                     Result, Long, ALUFlags, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        int lat, bc;
        do_op(4'd1, 32'd5, 32'd5, lat, bc);
        n_tests++;
        if (Result !== 32'd0 || ALUFlags !== 4'b0110 || lat !== 1 || bc !== 0) begin
            n_fail++;
            $display("[TB] FAIL sub_equal: got R=%h F=%b lat=%0d busy=%0d, want 0 0110 1 0", Result, ALUFlags, lat, bc);
        end
        do_op(4'd0, 32'h7FFF_FFFF, 32'd1, lat, bc);
        n_tests++;
        if (Result !== 32'h8000_0000 || ALUFlags !== 4'b1001) begin
            n_fail++;
            $display("[TB] FAIL add_overflow: got R=%h F=%b, want 80000000 1001", Result, ALUFlags);
        end
        do_op(4'd5, 32'hFFFF_FFFE, 32'd3, lat, bc);
        n_tests++;
        if ({Long, Result} !== 64'hFFFF_FFFF_FFFF_FFFA || ALUFlags !== 4'b1000 || lat !== 33 || bc !== 32) begin
            n_fail++;
            $display("[TB] FAIL smul_neg: got P=%h F=%b lat=%0d busy=%0d, want FFFFFFFFFFFFFFFA 1000 33 32",
                     {Long, Result}, ALUFlags, lat, bc);
        end
        do_op(4'd7, 32'd100, 32'd0, lat, bc);
        n_tests++;
        if (Result !== 32'hFFFF_FFFF || Long !== 32'h64 || ALUFlags[0] !== 1'b1 || lat !== 33) begin
            n_fail++;
            $display("[TB] FAIL udiv_zero: got R=%h L=%h F=%b lat=%0d, want FFFFFFFF 64 V=1 33", Result, Long, ALUFlags, lat);
        end
        do_op(4'd13, 32'hFFFF_FFF9, 32'd2, lat, bc);
        n_tests++;
        if (Result !== 32'hFFFF_FFFD || Long !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL sdiv_neg: got R=%h L=%h, want FFFFFFFD FFFFFFFF", Result, Long);
        end
        do_op(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        n_tests++;
        if (Result !== 32'h8000_0000 || Long !== 32'd0 || ALUFlags[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sdiv_ovf: got R=%h L=%h F=%b, want 80000000 0 V=1", Result, Long, ALUFlags);
        end
        do_op(4'd14, 32'd9, 32'd9, lat, bc);
        n_tests++;
        if (Result !== 32'd0 || Long !== 32'd0 || ALUFlags !== 4'b0100 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL reserved: got R=%h L=%h F=%b lat=%0d, want 0 0 0100 1", Result, Long, ALUFlags, lat);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [3:0]  op;
        logic [31:0] x, y, er, el;
        logic [3:0]  ef;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'($urandom_range(0, 40));
                2: y = 32'hFFFF_FFFF;
                default: y = 32'($urandom);
            endcase
            model(op, x, y, er, el, ef);
            do_op(op, x, y, lat, bc);
            n_tests++;
            if (Result !== er || Long !== el || ALUFlags !== ef) begin
                n_fail++;
                $display("[TB] FAIL rand_value op=%0d a=%h b=%h: got R=%h L=%h F=%b, want R=%h L=%h F=%b",
                         op, x, y, Result, Long, ALUFlags, er, el, ef);
            end
            n_tests++;
            if (lat !== (is_iter_op(op) ? 33 : 1) || bc !== (is_iter_op(op) ? 32 : 0)) begin
                n_fail++;
                $display("[TB] FAIL rand_timing op=%0d: got lat=%0d busy=%0d, want %0d %0d",
                         op, lat, bc, is_iter_op(op) ? 33 : 1, is_iter_op(op) ? 32 : 0);
            end
            @(posedge clk); #1;
            n_tests++;
            if (done !== 1'b0 || Result !== er || Long !== el || ALUFlags !== ef) begin
                n_fail++;
                $display("[TB] FAIL rand_hold op=%0d: got done=%b R=%h L=%h F=%b, want done=0 R=%h L=%h F=%b",
                         op, done, Result, Long, ALUFlags, er, el, ef);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int dones;
        logic [31:0] x, y;
        logic [63:0] p;
        x = $urandom; y = $urandom;
        p = 64'(x) * 64'(y);
        @(negedge clk);
        a = x; b = y; ALUControl = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 1; dones = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 10) begin
                start = 1'b1; ALUControl = 4'd0; a = 32'd1; b = 32'd2;
            end else begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat !== 33 || {Long, Result} !== p) begin
            n_fail++;
            $display("[TB] FAIL busy_ignore: got lat=%0d P=%h, want 33 %h", lat, {Long, Result}, p);
        end
        start = 1'b1; ALUControl = 4'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (done !== 1'b1 || Result !== 32'd7 || Long !== 32'd0 || ALUFlags !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL back_to_back: got done=%b R=%h L=%h F=%b, want 1 7 0 0000", done, Result, Long, ALUFlags);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("[TB] FAIL extra_done: got %0d pulses, want 0", dones);
        end
    endtask

    task automatic test_reset_midrun();
        int lat, bc, dones;
        do_op(4'd0, 32'h1234_5678, 32'h1111_1111, lat, bc);
        @(negedge clk);
        a = 32'd1000; b = 32'd7; ALUControl = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({Result, Long, ALUFlags, busy, done} !== 70'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_midrun: got R=%h L=%h F=%b busy=%b done=%b, want all 0",
                     Result, Long, ALUFlags, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done: got %0d busy/done cycles, want 0", dones);
        end
        do_op(4'd12, 32'h8000_0000, 32'd40, lat, bc);
        n_tests++;
        if (Result !== 32'hFFFF_FFFF || ALUFlags !== 4'b1000 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL asr_big: got R=%h F=%b lat=%0d, want FFFFFFFF 1000 1", Result, ALUFlags, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
